// File: rtl/core_abuf_replay_pkg.sv
// Shared types and sizing helpers for the activation-buffer replay core.
package core_abuf_replay_pkg;

    typedef struct packed {
        logic empty;
        logic reuse_empty;
        logic full;
        logic almost_full;
    } abuf_status_t;

    // Pointer carries one extra wrap bit above the address bits.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/core_abuf_replay_mem.sv
// Simple dual-port ABUF storage: one write port, one registered read port.
module mem_dp_abuf_v2 #(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 64
) (
    input  logic                     clk,
    input  logic                     wen,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     ren,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read returns the pre-write contents when both ports hit one address.
    always_ff @(posedge clk) begin
        if (wen) mem[waddr] <= wdata;
        if (ren) rdata <= mem[raddr];
    end

endmodule

// File: rtl/core_abuf_replay.sv
// Link-beat packer feeding a FIFO activation buffer with a non-consuming replay pointer.
module core_abuf_replay
    import core_abuf_replay_pkg::*;
#(
    parameter int GBUS_DATA   = 64,
    parameter int PACK        = 4,
    parameter int ABUF_DEPTH  = 64,
    parameter int ALERT_DEPTH = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [GBUS_DATA-1:0]          clink_wdata,
    input  logic                          clink_wen,
    output logic [GBUS_DATA-1:0]          clink_rdata,
    output logic                          clink_rvalid,
    input  logic                          pack_flush,
    input  logic                          abuf_ren,
    input  logic                          abuf_reuse_ren,
    input  logic                          abuf_reuse_rst,
    output logic [GBUS_DATA*PACK-1:0]     abuf_rdata,
    output logic                          abuf_rvalid,
    output logic                          abuf_empty,
    output logic                          abuf_reuse_empty,
    output logic                          abuf_full,
    output logic                          abuf_almost_full,
    output logic [$clog2(ABUF_DEPTH):0]   abuf_count,
    output logic                          abuf_ovf,
    output logic                          abuf_udf
);

    localparam int ABUF_DATA = GBUS_DATA * PACK;
    localparam int PW        = ptr_w(ABUF_DEPTH);
    localparam int AW        = PW - 1;
    localparam int CW        = cnt_w(PACK);

    // ---- stage p0: link register ----
    logic [GBUS_DATA-1:0] beat_p0;
    logic                 vld_p0;
    logic                 drop_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_p0 <= '0;
            vld_p0  <= 1'b0;
            drop_p0 <= 1'b0;
        end else begin
            vld_p0  <= clink_wen;
            drop_p0 <= clink_wen & pack_flush;
            if (clink_wen) beat_p0 <= clink_wdata;
        end
    end

    assign clink_rdata  = beat_p0;
    assign clink_rvalid = vld_p0;

    // ---- stage p1: packer ----
    logic [CW-1:0]        cnt_p1;
    logic [ABUF_DATA-1:0] word_p1;
    logic                 wreq_p1;
    logic                 beat_take;

    // A beat that arrived alongside a flush is discarded one cycle later.
    assign beat_take = vld_p0 & ~drop_p0 & ~pack_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p1  <= '0;
            wreq_p1 <= 1'b0;
        end else begin
            wreq_p1 <= 1'b0;
            if (pack_flush) begin
                cnt_p1 <= '0;
            end else if (beat_take) begin
                if (cnt_p1 == CW'(PACK - 1)) begin
                    cnt_p1  <= '0;
                    wreq_p1 <= 1'b1;
                end else begin
                    cnt_p1 <= cnt_p1 + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < PACK; k++) begin
            if (beat_take && cnt_p1 == CW'(k))
                word_p1[k*GBUS_DATA +: GBUS_DATA] <= beat_p0;
        end
    end

    // ---- stage p2: buffer pointers and status ----
    logic [PW-1:0] wptr, rptr, uptr;
    logic [PW-1:0] wptr_nxt, rptr_nxt, uptr_nxt;
    logic [PW-1:0] count;
    logic [PW-1:0] span_u, span_w;
    logic          pop, rep, wr;
    logic          ovf_evt, udf_evt;
    abuf_status_t  st;

    assign count          = wptr - rptr;
    assign st.empty       = (rptr == wptr);
    assign st.reuse_empty = (uptr == wptr);
    assign st.full        = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign st.almost_full = (count >= PW'(ABUF_DEPTH - ALERT_DEPTH));

    assign pop = abuf_ren & ~st.empty;
    assign rep = abuf_reuse_ren & ~abuf_ren & ~st.reuse_empty;
    // A pop in the same cycle frees the slot a full-buffer write needs.
    assign wr  = wreq_p1 & (~st.full | pop);

    assign ovf_evt = wreq_p1 & st.full & ~pop;
    assign udf_evt = (abuf_ren & st.empty) | (abuf_reuse_ren & ~abuf_ren & st.reuse_empty);

    always_comb begin
        wptr_nxt = wptr;
        rptr_nxt = rptr;
        uptr_nxt = uptr;
        if (wr)  wptr_nxt = wptr + 1'b1;
        if (pop) rptr_nxt = rptr + 1'b1;
        if (abuf_reuse_rst) begin
            uptr_nxt = rptr_nxt;
        end else if ((pop && !st.reuse_empty) || rep) begin
            uptr_nxt = uptr + 1'b1;
        end
        // Modular distances: a replay pointer behind rptr looks further than wptr.
        span_u = uptr_nxt - rptr_nxt;
        span_w = wptr_nxt - rptr_nxt;
        if (span_u > span_w) uptr_nxt = rptr_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr        <= '0;
            rptr        <= '0;
            uptr        <= '0;
            abuf_rvalid <= 1'b0;
            abuf_ovf    <= 1'b0;
            abuf_udf    <= 1'b0;
        end else begin
            wptr        <= wptr_nxt;
            rptr        <= rptr_nxt;
            uptr        <= uptr_nxt;
            abuf_rvalid <= pop | rep;
            if (ovf_evt) abuf_ovf <= 1'b1;
            if (udf_evt) abuf_udf <= 1'b1;
        end
    end

    assign abuf_empty       = st.empty;
    assign abuf_reuse_empty = st.reuse_empty;
    assign abuf_full        = st.full;
    assign abuf_almost_full = st.almost_full;
    assign abuf_count       = count;

    mem_dp_abuf_v2 #(
        .DATA_W (ABUF_DATA),
        .DEPTH  (ABUF_DEPTH)
    ) u_mem (
        .clk   (clk),
        .wen   (wr),
        .waddr (wptr[AW-1:0]),
        .wdata (word_p1),
        .ren   (pop | rep),
        .raddr (pop ? rptr[AW-1:0] : uptr[AW-1:0]),
        .rdata (abuf_rdata)
    );

endmodule

// File: tb/tb_core_abuf_replay.sv
// Directed bench for core_abuf_replay with a read-data scoreboard.
module tb_core_abuf_replay;

    localparam int G  = 64;
    localparam int P  = 4;
    localparam int D  = 64;
    localparam int AL = 3;
    localparam int AD = G * P;
    localparam int CNTW = $clog2(D) + 1;

    logic            clk;
    logic            rst;
    logic [G-1:0]    clink_wdata;
    logic            clink_wen;
    logic [G-1:0]    clink_rdata;
    logic            clink_rvalid;
    logic            pack_flush;
    logic            abuf_ren;
    logic            abuf_reuse_ren;
    logic            abuf_reuse_rst;
    logic [AD-1:0]   abuf_rdata;
    logic            abuf_rvalid;
    logic            abuf_empty;
    logic            abuf_reuse_empty;
    logic            abuf_full;
    logic            abuf_almost_full;
    logic [CNTW-1:0] abuf_count;
    logic            abuf_ovf;
    logic            abuf_udf;

    int tests = 0;
    int fails = 0;
    logic [AD-1:0] ref_q[$];
    logic [AD-1:0] exp_q[$];
    int ui = 0;

    core_abuf_replay #(
        .GBUS_DATA   (G),
        .PACK        (P),
        .ABUF_DEPTH  (D),
        .ALERT_DEPTH (AL)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .clink_wdata      (clink_wdata),
        .clink_wen        (clink_wen),
        .clink_rdata      (clink_rdata),
        .clink_rvalid     (clink_rvalid),
        .pack_flush       (pack_flush),
        .abuf_ren         (abuf_ren),
        .abuf_reuse_ren   (abuf_reuse_ren),
        .abuf_reuse_rst   (abuf_reuse_rst),
        .abuf_rdata       (abuf_rdata),
        .abuf_rvalid      (abuf_rvalid),
        .abuf_empty       (abuf_empty),
        .abuf_reuse_empty (abuf_reuse_empty),
        .abuf_full        (abuf_full),
        .abuf_almost_full (abuf_almost_full),
        .abuf_count       (abuf_count),
        .abuf_ovf         (abuf_ovf),
        .abuf_udf         (abuf_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [AD-1:0] obs, input logic [AD-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every read response must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && abuf_rvalid) begin
            if (exp_q.size() == 0) chk("rvalid_unexpected", abuf_rvalid, 1'b0);
            else                   chk("rdata", abuf_rdata, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        ref_q.delete();
        exp_q.delete();
        ui = 0;
    endtask

    function automatic logic [AD-1:0] mkword(input int i);
        logic [AD-1:0] w;
        for (int k = 0; k < P; k++) w[k*G +: G] = {16'hA5A5, 16'(k), 32'(i)};
        return w;
    endfunction

    task automatic model_pop();
        if (ref_q.size() > 0) begin
            if (ui == ref_q.size() && ui > 0) ui--;
            exp_q.push_back(ref_q.pop_front());
        end
    endtask

    task automatic beat(input logic [G-1:0] d, input bit ren);
        clink_wdata = d;
        clink_wen   = 1'b1;
        if (ren) model_pop();
        abuf_ren = ren;
        tick();
        clink_wen = 1'b0;
        abuf_ren  = 1'b0;
    endtask

    task automatic send_word(input logic [AD-1:0] w, input bit pop_first);
        for (int k = 0; k < P; k++) beat(w[k*G +: G], pop_first && (k == 0));
        if (ref_q.size() < D) ref_q.push_back(w);
    endtask

    task automatic settle();
        tick();
        tick();
    endtask

    task automatic do_pop();
        model_pop();
        abuf_ren = 1'b1;
        tick();
        abuf_ren = 1'b0;
    endtask

    task automatic do_reuse();
        exp_q.push_back(ref_q[ui]);
        ui++;
        abuf_reuse_ren = 1'b1;
        tick();
        abuf_reuse_ren = 1'b0;
    endtask

    initial begin
        clink_wdata    = '0;
        clink_wen      = 1'b0;
        pack_flush     = 1'b0;
        abuf_ren       = 1'b0;
        abuf_reuse_ren = 1'b0;
        abuf_reuse_rst = 1'b0;
        do_reset();

        // reset state
        chk("rst_clink_rvalid", clink_rvalid, 1'b0);
        chk("rst_clink_rdata", clink_rdata, '0);
        chk("rst_abuf_rvalid", abuf_rvalid, 1'b0);
        chk("rst_empty", abuf_empty, 1'b1);
        chk("rst_reuse_empty", abuf_reuse_empty, 1'b1);
        chk("rst_full", abuf_full, 1'b0);
        chk("rst_almost_full", abuf_almost_full, 1'b0);
        chk("rst_count", abuf_count, 0);
        chk("rst_ovf", abuf_ovf, 1'b0);
        chk("rst_udf", abuf_udf, 1'b0);

        // lane order and link forwarding
        clink_wdata = 64'h1;
        clink_wen   = 1'b1;
        chk("clink_rvalid_pre", clink_rvalid, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            beat(G'(k), 1'b0);
            chk("clink_rvalid_beat", clink_rvalid, 1'b1);
            chk("clink_rdata_beat", clink_rdata, G'(k));
        end
        ref_q.push_back({64'h4, 64'h3, 64'h2, 64'h1});
        tick();
        chk("clink_rvalid_idle", clink_rvalid, 1'b0);
        tick();
        chk("pack_count1", abuf_count, 1);
        chk("pack_not_empty", abuf_empty, 1'b0);
        do_pop();
        tick();
        chk("pack_empty_after_pop", abuf_empty, 1'b1);

        // flush discards partial word, and a beat coincident with flush
        beat(64'h11, 1'b0);
        beat(64'h12, 1'b0);
        tick();
        pack_flush = 1'b1;
        tick();
        pack_flush = 1'b0;
        for (int k = 0; k < 4; k++) beat(G'(8'h21 + k), 1'b0);
        ref_q.push_back({64'h24, 64'h23, 64'h22, 64'h21});
        settle();
        chk("flush_count", abuf_count, 1);
        pack_flush = 1'b1;
        beat(64'h31, 1'b0);
        pack_flush = 1'b0;
        for (int k = 0; k < 4; k++) beat(G'(8'h41 + k), 1'b0);
        ref_q.push_back({64'h44, 64'h43, 64'h42, 64'h41});
        settle();
        chk("flush_coincident_count", abuf_count, 2);
        do_pop();
        do_pop();
        tick();

        // underflow on empty
        abuf_ren = 1'b1;
        tick();
        abuf_ren = 1'b0;
        chk("udf_rvalid", abuf_rvalid, 1'b0);
        chk("udf_flag", abuf_udf, 1'b1);
        chk("udf_count", abuf_count, 0);
        chk("udf_empty", abuf_empty, 1'b1);
        do_reset();
        chk("udf_cleared", abuf_udf, 1'b0);

        // replay then consume
        for (int i = 0; i < 8; i++) send_word(mkword(100 + i), 1'b0);
        settle();
        chk("replay_count_wr", abuf_count, 8);
        for (int i = 0; i < 8; i++) do_reuse();
        tick();
        chk("replay_reuse_empty", abuf_reuse_empty, 1'b1);
        chk("replay_count_kept", abuf_count, 8);
        abuf_reuse_rst = 1'b1;
        tick();
        abuf_reuse_rst = 1'b0;
        ui = 0;
        chk("replay_rst_reuse_empty", abuf_reuse_empty, 1'b0);
        abuf_reuse_ren = 1'b1;
        do_pop();
        abuf_reuse_ren = 1'b0;
        for (int i = 1; i < 8; i++) do_pop();
        tick();
        chk("replay_empty", abuf_empty, 1'b1);
        chk("replay_reuse_empty_end", abuf_reuse_empty, 1'b1);
        chk("replay_no_udf", abuf_udf, 1'b0);

        // fill to full, then overflow
        do_reset();
        for (int i = 1; i <= 65; i++) begin
            send_word(mkword(i), 1'b0);
            settle();
            if (i == 60) chk("af_at60", abuf_almost_full, 1'b0);
            if (i == 61) chk("af_at61", abuf_almost_full, 1'b1);
            if (i == 63) chk("full_at63", abuf_full, 1'b0);
            if (i == 64) chk("full_at64", abuf_full, 1'b1);
            if (i == 64) chk("no_ovf_at64", abuf_ovf, 1'b0);
        end
        chk("ovf_flag", abuf_ovf, 1'b1);
        chk("ovf_count", abuf_count, 64);
        chk("ovf_full", abuf_full, 1'b1);
        for (int i = 0; i < 64; i++) do_pop();
        tick();
        chk("full_drain_empty", abuf_empty, 1'b1);

        // wrap with concurrent pops
        do_reset();
        send_word(mkword(1000), 1'b0);
        send_word(mkword(1001), 1'b0);
        for (int i = 2; i < 200; i++) send_word(mkword(1000 + i), 1'b1);
        settle();
        chk("wrap_count", abuf_count, 2);
        do_pop();
        do_pop();
        tick();
        chk("wrap_empty", abuf_empty, 1'b1);
        chk("wrap_no_ovf", abuf_ovf, 1'b0);
        chk("wrap_no_udf", abuf_udf, 1'b0);

        chk("scoreboard_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/core_abuf_replay.md
CORE_ABUF_REPLAY -- requirements
Module: core_abuf_replay

Interface
REQ-001 Parameter GBUS_DATA, default 64, width of the core-to-core link beat in bits.
REQ-002 Parameter PACK, default 4, GBUS beats per ABUF word (>=1); ABUF_DATA = GBUS_DATA*PACK.
REQ-003 Parameter ABUF_DEPTH, default 64, number of ABUF words (power of two, >=4).
REQ-004 Parameter ALERT_DEPTH, default 3, free-entry threshold for almost-full.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 clink_wdata  input  GBUS_DATA  incoming link beat.
REQ-008 clink_wen  input  1  beat valid.
REQ-009 clink_rdata  output  GBUS_DATA  registered forward of last accepted beat.
REQ-010 clink_rvalid  output  1  clink_wen delayed one cycle.
REQ-011 pack_flush  input  1  discard a partially packed word.
REQ-012 abuf_ren  input  1  consuming read (pop).
REQ-013 abuf_reuse_ren  input  1  non-consuming replay read.
REQ-014 abuf_reuse_rst  input  1  reload replay pointer from read pointer.
REQ-015 abuf_rdata  output  ABUF_DATA  read data.
REQ-016 abuf_rvalid  output  1  abuf_rdata valid this cycle.
REQ-017 abuf_empty / abuf_reuse_empty / abuf_full / abuf_almost_full  output  1 each  status flags.
REQ-018 abuf_count  output  $clog2(ABUF_DEPTH)+1  occupied words.
REQ-019 abuf_ovf / abuf_udf  output  1 each  sticky overflow / underflow error flags.

Function
REQ-020 Link stage: on clink_wen, register clink_wdata; clink_rdata/clink_rvalid SHALL appear one cycle later; no backpressure.
REQ-021 Packer: registered beat k (0..PACK-1) SHALL land in bits [k*GBUS_DATA +: GBUS_DATA]; beat counter wraps at PACK; word write request asserted the cycle after beat PACK-1 is registered.
REQ-022 pack_flush SHALL zero the beat counter the same cycle and drop any partial word; flush coincident with a valid beat drops that beat too.
REQ-023 Pointers wptr, rptr, uptr SHALL be $clog2(ABUF_DEPTH)+1 bits with MSB wrap bit; empty = (rptr==wptr); full = MSBs differ and low bits equal; reuse_empty = (uptr==wptr).
REQ-024 abuf_count = wptr-rptr (modulo); almost_full = (count >= ABUF_DEPTH-ALERT_DEPTH).
REQ-025 Write when full SHALL be dropped, wptr unchanged, abuf_ovf set.
REQ-026 abuf_ren when not empty SHALL read mem[rptr], increment rptr and uptr; when empty, no pointer change, abuf_udf set.
REQ-027 abuf_reuse_ren (with abuf_ren low) when not reuse_empty SHALL read mem[uptr] and increment uptr only; when reuse_empty, ignored, abuf_udf set.
REQ-028 abuf_ren and abuf_reuse_ren both high: abuf_ren wins, replay request ignored, no error.
REQ-029 abuf_reuse_rst SHALL set uptr := rptr (post-pop value if abuf_ren pops the same cycle) and overrides any uptr increment that cycle.
REQ-030 Read latency one cycle: abuf_rvalid high exactly one cycle after an accepted read; abuf_rdata held until next accepted read.
REQ-031 Simultaneous write and pop SHALL both succeed even when full (pop first frees slot) or empty (write proceeds, read flagged underflow).
REQ-032 uptr SHALL never lag rptr: if rptr passes uptr, uptr follows rptr.

Reset
REQ-033 rst SHALL clear all pointers, beat counter, abuf_rvalid, clink_rvalid, clink_rdata, abuf_ovf, abuf_udf; empty and reuse_empty read 1, full/almost_full 0, count 0.
REQ-034 Memory array and abuf_rdata SHALL not be reset; rst mid-packing discards the partial word.

Structure
REQ-035 Pointer-width helper and status-flag struct belong in the shared core package; parameters stay module-local.
REQ-036 Storage SHALL be a separate sub-module mem_dp_abuf_v2 (1W1R, registered read, ren-gated).

Verification
REQ-037 PACK=4, beats 0x1..0x4 -> one word 0x4_3_2_1 (lane order), count=1, clink_rvalid trails each clink_wen by 1.
REQ-038 Fill 64 words -> full=1, almost_full from count=61; 65th word -> dropped, abuf_ovf=1, count=64.
REQ-039 Write 8 words, reuse_ren x8 -> words 0..7, reuse_empty=1, count=8; reuse_rst, abuf_ren x8 -> same 0..7, empty=1.
REQ-040 Two beats then pack_flush, four beats -> one word built from the last four beats only.
REQ-041 abuf_ren on empty -> abuf_rvalid=0, abuf_udf=1, pointers unchanged; rst clears udf.
REQ-042 Wrap: 200 words streamed with concurrent pops -> data order preserved, no ovf/udf.
